fir_acc_sequencer: RTL and testbench

- Sequences one shared, combinational 16-bit prefix adder to accumulate NTAPS signed 32-bit tap products into one 32-bit FIR output sample.
- Each 32-bit add takes two adder passes: low half first, then high half with the registered carry.
- Sits between the tap-product source and the FIR output stage.
- The adder instance is external; this block drives its operands and reads its sum and carry.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_acc_sequencer.sv | 151 +++++++++++++++
 tb/tb_fir_acc_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap-product accumulator.
//   fir_state_e          : sequencer states (IDLE, ADD_LO, ADD_HI, OUT)
//   ADD_W_DEF, NTAPS_DEF : default shared-adder width and taps per sample
//   SAT_POS, SAT_NEG     : 32-bit clamp values used when FIR_ACC_SAT_EN is defined
package fir_pkg;

  localparam int unsigned ADD_W_DEF = 16;
  localparam int unsigned NTAPS_DEF = 8;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    OUT    = 2'd3
  } fir_state_e;

endpackage

// File: rtl/fir_acc_sequencer.sv
// fir_acc_sequencer
//   Accumulates NTAPS signed (2*ADD_W)-bit tap products into one output sample
//   by sequencing an external, combinational ADD_W-bit adder: every product
//   takes one pass for the low half and one for the high half with the carry.
//   Optional macro FIR_ACC_SAT_EN: clamp the accumulator on signed overflow
//   instead of wrapping (OUT_OVF is raised either way).
// Ports
//   CLK, RST_N                  clock, synchronous active-low reset
//   PROD_VALID/PROD_READY/PROD  tap-product input handshake
//   OUT_VALID/OUT_READY         output sample handshake
//   OUT_DATA, OUT_OVF           accumulated sample and its overflow flag
//   BUSY                        high unless idle with no partial accumulation
//   ADD_A, ADD_B, ADD_CIN       operands driven to the shared adder
//   ADD_Y, ADD_COUT             sum and carry returned by the shared adder
module fir_acc_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned ADD_W = ADD_W_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               PROD_VALID,
  output logic               PROD_READY,
  input  logic [2*ADD_W-1:0] PROD,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*ADD_W-1:0] OUT_DATA,
  output logic               OUT_OVF,
  output logic               BUSY,
  output logic [ADD_W-1:0]   ADD_A,
  output logic [ADD_W-1:0]   ADD_B,
  output logic               ADD_CIN,
  input  logic [ADD_W-1:0]   ADD_Y,
  input  logic               ADD_COUT
);

  localparam int unsigned DW = 2 * ADD_W;
  localparam int unsigned CW = $clog2(NTAPS);
  localparam logic [CW-1:0] LAST_TAP = CW'(NTAPS - 1);

  fir_state_e      state;
  logic [DW-1:0]   acc;
  logic [DW-1:0]   prod_q;
  logic            carry_q;
  logic [CW-1:0]   count;
  logic            ovf;

  logic            prod_ready_q;
  logic            out_valid_q;
  logic [DW-1:0]   out_data_q;
  logic            out_ovf_q;

  logic            hi_ovf;
  logic [DW-1:0]   acc_next;

  // Overflow is judged on the high-half pass: same operand signs, different result sign.
  always_comb begin
    hi_ovf   = (acc[DW-1] == prod_q[DW-1]) && (ADD_Y[ADD_W-1] != acc[DW-1]);
    acc_next = {ADD_Y, acc[ADD_W-1:0]};
`ifdef FIR_ACC_SAT_EN
    if (hi_ovf) begin
      acc_next = acc[DW-1] ? SAT_NEG : SAT_POS;
    end
`endif
  end

  // Operands are a pure decode of registered state, so the adder sees stable inputs all cycle.
  always_comb begin
    ADD_A   = '0;
    ADD_B   = '0;
    ADD_CIN = 1'b0;
    unique case (state)
      ADD_LO: begin
        ADD_A = acc[ADD_W-1:0];
        ADD_B = prod_q[ADD_W-1:0];
      end
      ADD_HI: begin
        ADD_A   = acc[DW-1:ADD_W];
        ADD_B   = prod_q[DW-1:ADD_W];
        ADD_CIN = carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      acc          <= '0;
      prod_q       <= '0;
      carry_q      <= 1'b0;
      count        <= '0;
      ovf          <= 1'b0;
      prod_ready_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (PROD_VALID) begin
            prod_q       <= PROD;
            prod_ready_q <= 1'b0;
            state        <= ADD_LO;
          end
        end
        ADD_LO: begin
          acc[ADD_W-1:0] <= ADD_Y;
          carry_q        <= ADD_COUT;
          state          <= ADD_HI;
        end
        ADD_HI: begin
          acc     <= acc_next;
          ovf     <= ovf | hi_ovf;
          carry_q <= 1'b0;
          if (count == LAST_TAP) begin
            count       <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_next;
            out_ovf_q   <= ovf | hi_ovf;
            state       <= OUT;
          end else begin
            count        <= count + 1'b1;
            prod_ready_q <= 1'b1;
            state        <= IDLE;
          end
        end
        OUT: begin
          if (OUT_READY) begin
            acc          <= '0;
            ovf          <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ovf_q    <= 1'b0;
            prod_ready_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign PROD_READY = prod_ready_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_DATA   = out_data_q;
  assign OUT_OVF    = out_ovf_q;
  assign BUSY       = !((state == IDLE) && (count == '0));

endmodule

// File: tb/tb_fir_acc_sequencer.sv
// Self-checking bench for fir_acc_sequencer with a behavioural 16-bit shared adder.
module tb_fir_acc_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        PROD_VALID;
  logic        PROD_READY;
  logic [31:0] PROD;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic        OUT_OVF;
  logic        BUSY;
  logic [15:0] ADD_A;
  logic [15:0] ADD_B;
  logic        ADD_CIN;
  logic [15:0] ADD_Y;
  logic        ADD_COUT;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned last_accept = 0;

  fir_acc_sequencer #(.NTAPS(8), .ADD_W(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PROD_VALID (PROD_VALID),
    .PROD_READY (PROD_READY),
    .PROD       (PROD),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_DATA   (OUT_DATA),
    .OUT_OVF    (OUT_OVF),
    .BUSY       (BUSY),
    .ADD_A      (ADD_A),
    .ADD_B      (ADD_B),
    .ADD_CIN    (ADD_CIN),
    .ADD_Y      (ADD_Y),
    .ADD_COUT   (ADD_COUT)
  );

  // Shared adder owned by the parent in the real system.
  assign {ADD_COUT, ADD_Y} = {1'b0, ADD_A} + {1'b0, ADD_B} + {16'd0, ADD_CIN};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rest;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [31:0] d);
    int unsigned t = 0;
    PROD_VALID = 1'b1;
    PROD       = d;
    while (!PROD_READY && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("prod_ready_wait", {31'd0, PROD_READY}, 32'd1);
    last_accept = cyc;
    @(negedge CLK);
    PROD_VALID = 1'b0;
    PROD       = '0;
  endtask

  task automatic wait_out();
    int unsigned t = 0;
    while (!OUT_VALID && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk("out_valid_wait", {31'd0, OUT_VALID}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int unsigned t0;
    push(v.a);
    t0 = last_accept;
    push(v.b);
    for (int i = 0; i < 6; i++) push(v.rest);
    wait_out();
    chk({name, "_latency"}, 32'(cyc - t0), 32'd24);
    chk({name, "_data"}, OUT_DATA, v.exp_data);
    chk({name, "_ovf"}, {31'd0, OUT_OVF}, {31'd0, v.exp_ovf});
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{a: 32'h0000_0001, b: 32'h0000_0001, rest: 32'h0000_0001,
                exp_data: 32'h0000_0008, exp_ovf: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, rest: 32'hFFFF_FFFF,
                exp_data: 32'hFFFF_FFF8, exp_ovf: 1'b0};
`ifdef FIR_ACC_SAT_EN
    vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, rest: 32'h0,
                exp_data: 32'h7FFF_FFFF, exp_ovf: 1'b1};
    vecs[3] = '{a: 32'h8000_0000, b: 32'h8000_0000, rest: 32'h0,
                exp_data: 32'h8000_0000, exp_ovf: 1'b1};
`else
    vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, rest: 32'h0,
                exp_data: 32'hFFFF_FFFE, exp_ovf: 1'b1};
    vecs[3] = '{a: 32'h8000_0000, b: 32'h8000_0000, rest: 32'h0,
                exp_data: 32'h0000_0000, exp_ovf: 1'b1};
`endif
    vecs[4] = '{a: 32'h1234_5678, b: 32'hEDCB_A988, rest: 32'h0001_0000,
                exp_data: 32'h0006_0000, exp_ovf: 1'b0};

    RST_N      = 1'b0;
    PROD_VALID = 1'b0;
    PROD       = '0;
    OUT_READY  = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_prod_ready", {31'd0, PROD_READY}, 32'd1);
    chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("rst_out_data", OUT_DATA, 32'd0);
    chk("rst_out_ovf", {31'd0, OUT_OVF}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_add_ops", {ADD_A, ADD_B}, 32'd0);
    chk("rst_add_cin", {31'd0, ADD_CIN}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("vec%0d", k));
    @(negedge CLK);

    // Low-half carry must be presented as ADD_CIN on the second product's high pass.
    push(32'h0000_FFFF);
    chk("cin_busy", {31'd0, BUSY}, 32'd1);
    push(32'h0000_0001);
    chk("cin_lo_ops", {ADD_A, ADD_B}, {16'hFFFF, 16'h0001});
    chk("cin_lo_cin", {31'd0, ADD_CIN}, 32'd0);
    @(negedge CLK);
    chk("cin_hi_cin", {31'd0, ADD_CIN}, 32'd1);
    chk("cin_hi_ops", {ADD_A, ADD_B}, 32'd0);
    for (int i = 0; i < 6; i++) push(32'h0);
    wait_out();
    chk("cin_data", OUT_DATA, 32'h0001_0000);
    @(negedge CLK);

    // Output stall with a product pending; it must wait for the next IDLE cycle.
    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h0000_0003);
    wait_out();
    chk("stall_data0", OUT_DATA, 32'h0000_0018);
    PROD_VALID = 1'b1;
    PROD       = 32'h0000_0005;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_valid", {31'd0, OUT_VALID}, 32'd1);
      chk("stall_data", OUT_DATA, 32'h0000_0018);
      chk("stall_prod_ready", {31'd0, PROD_READY}, 32'd0);
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    chk("hs_out_valid", {31'd0, OUT_VALID}, 32'd0);
    chk("hs_prod_ready", {31'd0, PROD_READY}, 32'd1);
    chk("hs_out_data", OUT_DATA, 32'd0);
    @(negedge CLK);
    PROD_VALID = 1'b0;
    chk("next_lo_ops", {ADD_A, ADD_B}, {16'h0000, 16'h0005});
    for (int i = 0; i < 7; i++) push(32'h0000_0001);
    wait_out();
    chk("next_data", OUT_DATA, 32'h0000_000C);
    @(negedge CLK);

    // Reset mid-sample discards the partial sum.
    for (int i = 0; i < 3; i++) push(32'h0000_0100);
    chk("mid_busy", {31'd0, BUSY}, 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_ready", {31'd0, PROD_READY}, 32'd1);
    chk("mid_rst_ops", {ADD_A, ADD_B}, 32'd0);
    run_vec('{a: 32'h2, b: 32'h2, rest: 32'h2, exp_data: 32'h0000_0010, exp_ovf: 1'b0},
            "post_rst");
    @(negedge CLK);
    chk("end_busy", {31'd0, BUSY}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
